// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues one-cycle-latency
// reads to InstructionMemory and buffers returned words with their PCs in a
// small queue that feeds decode over a valid/ready handshake. A redirect
// from execute flushes the queue, drops any read in flight and restarts fetch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instruction_adress,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // One extra bit so the count can hold FIFO_DEPTH and count+inflight
    // cannot overflow the comparison.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_r;
    logic             inflight_r;
    logic [31:0]      inflight_pc_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [31:0]      q_instr_r [FIFO_DEPTH];
    logic [31:0]      q_pc_r    [FIFO_DEPTH];

    logic [CNT_W-1:0] occupancy_s;
    logic             have_head_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;

    assign instruction_adress = fetch_pc_r;

    // Control decisions: credit-based issue, response capture and decode pop.
    // The credit counts queued entries plus the read in flight, using the
    // current count only, so a returning word always has a free slot.
    always_comb begin
        occupancy_s = count_r + {{(CNT_W-1){1'b0}}, inflight_r};
        have_head_s = (count_r != {CNT_W{1'b0}});
        issue_s     = !rst && !redirect_valid && (occupancy_s < DEPTH_C);
        push_s      = !rst && !redirect_valid && inflight_r;
        pop_s       = !rst && !redirect_valid && have_head_s && if_ready;
    end

    // Head of the queue toward decode; zeroed whenever the queue is empty.
    always_comb begin
        if (have_head_s) begin
            if_valid       = 1'b1;
            if_instruction = q_instr_r[head_r];
            if_pc          = q_pc_r[head_r];
        end else begin
            if_valid       = 1'b0;
            if_instruction = 32'h0000_0000;
            if_pc          = 32'h0000_0000;
        end
    end

    // PC, in-flight tracking and queue pointers; reset beats redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            count_r       <= {CNT_W{1'b0}};
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
            inflight_r <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
        end else begin
            if (issue_s) begin
                inflight_r    <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + 32'd4;
            end else begin
                inflight_r <= 1'b0;
            end
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: captured word and its PC written at the tail.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_instr_r[tail_r] <= instruction;
            q_pc_r[tail_r]    <= inflight_pc_r;
        end
    end

    // A capture into a full queue means the credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_s && (count_r == DEPTH_C)));

endmodule
